debounce_filter: RTL



---
 rtl/debounce_filter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/debounce_filter.sv
// debounce_filter: turns a raw, possibly bouncing 1-bit level into a clean
// registered level, with one-cycle rise/fall pulses and a busy flag.
// Optional feature macro: DEBOUNCE_SYNC_EN (adds a 2-flop input synchroniser).
module debounce_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  // Count value held when the next agreeing sample completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_reg, sync2_reg;

  // Two-stage synchroniser so an asynchronous input settles before filtering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= in;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = sync2_reg;
`else
  assign s = in;
`endif

  // Next-state logic: qualify a level change over STABLE_CYCLES agreeing samples.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      IDLE_LO: begin
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_next = IDLE_HI;
            out_next   = 1'b1;
            rise_next  = 1'b1;
          end else begin
            state_next = WAIT_HI;
            cnt_next   = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!s) begin
          // Disagreeing sample abandons the qualification silently.
          state_next = IDLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_HI;
          out_next   = 1'b1;
          rise_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_next = IDLE_LO;
            out_next   = 1'b0;
            fall_next  = 1'b1;
          end else begin
            state_next = WAIT_LO;
            cnt_next   = CNT_ONE;
          end
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_next = IDLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_LO;
          out_next   = 1'b0;
          fall_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LO;
        cnt_next   = '0;
        out_next   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any qualification in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE_LO;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign out  = out_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign busy = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);

endmodule
